// File: rtl/crc_check_pkg.sv
// Shared types and helpers for the receive-side CRC checker.
// Holds the delay-line state encoding and the FCS word-count helper.
package crc_check_pkg;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic int fcs_words(input int crc_size, input int data_width);
    return crc_size / data_width;
  endfunction

endpackage

// File: rtl/crc_calc.sv
// Word-serial CRC engine (Rocksoft model). crc_o is a lookahead value: it already
// includes the word presented this cycle, reflected and XOR_OUT applied.
module crc_calc #(
  parameter int                  CRC_SIZE   = 16,
  parameter int                  DATA_WIDTH = 8,
  parameter logic [CRC_SIZE-1:0] POLY       = 16'h8005,
  parameter logic [CRC_SIZE-1:0] INIT       = 16'h0000,
  parameter bit                  REF_IN     = 1'b1,
  parameter bit                  REF_OUT    = 1'b1,
  parameter logic [CRC_SIZE-1:0] XOR_OUT    = 16'hffff
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  logic [CRC_SIZE-1:0]   crc_q;
  logic [CRC_SIZE-1:0]   crc_d;
  logic [CRC_SIZE-1:0]   crc_r;
  logic [DATA_WIDTH-1:0] din;

  function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0]   crc,
                                                   input logic [DATA_WIDTH-1:0] data);
    logic [CRC_SIZE-1:0] c;
    logic                fb;
    c = crc;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_SIZE-1] ^ data[i];
      c  = {c[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    din   = data_i;
    crc_d = crc_q;
    crc_r = '0;
    if (REF_IN) begin
      for (int i = 0; i < DATA_WIDTH; i++) din[i] = data_i[DATA_WIDTH-1-i];
    end
    if (valid_i) crc_d = crc_step(crc_q, din);
    crc_r = crc_d;
    if (REF_OUT) begin
      for (int i = 0; i < CRC_SIZE; i++) crc_r[i] = crc_d[CRC_SIZE-1-i];
    end
    crc_o = crc_r ^ XOR_OUT;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i || soft_reset_i) crc_q <= INIT;
    else                       crc_q <= crc_d;
  end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC checker: delays the stream by the FCS length, forwards payload,
// recomputes the CRC over it and reports a registered per-frame verdict.
module crc_check
  import crc_check_pkg::*;
#(
  parameter int                  CRC_SIZE      = 16,
  parameter int                  DATA_WIDTH    = 8,
  parameter logic [CRC_SIZE-1:0] POLY          = 16'h8005,
  parameter logic [CRC_SIZE-1:0] INIT          = 16'h0000,
  parameter bit                  REF_IN        = 1'b1,
  parameter bit                  REF_OUT       = 1'b1,
  parameter logic [CRC_SIZE-1:0] XOR_OUT       = 16'hffff,
  parameter bit                  FCS_LSB_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  done_o,
  output logic                  crc_ok_o,
  output logic                  runt_o,
  output logic [CRC_SIZE-1:0]   rx_crc_o,
  output logic [CRC_SIZE-1:0]   calc_crc_o
);

  localparam int             N        = fcs_words(CRC_SIZE, DATA_WIDTH);
  localparam int             CW       = $clog2(N + 1);
  localparam logic [CW-1:0]  FILL_MAX = CW'(N - 1);

  if (CRC_SIZE % DATA_WIDTH != 0) begin : g_bad_size
    $error("crc_check: CRC_SIZE must be a multiple of DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] sr_q [N];
  logic [DATA_WIDTH-1:0] fcs_w [N];
  state_e                state_q;
  logic [CW-1:0]         fcnt_q;
  logic                  post_last_q;
  logic                  valid_q, last_q, done_q, ok_q, runt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CRC_SIZE-1:0]   rx_q, calc_q;
  logic                  pop;
  logic [CRC_SIZE-1:0]   rx_fcs;
  logic [CRC_SIZE-1:0]   calc_crc;

  assign pop = valid_i && (state_q == ST_STREAM);

  crc_calc #(
    .CRC_SIZE  (CRC_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .POLY      (POLY),
    .INIT      (INIT),
    .REF_IN    (REF_IN),
    .REF_OUT   (REF_OUT),
    .XOR_OUT   (XOR_OUT)
  ) u_crc_calc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .soft_reset_i(post_last_q),
    .valid_i     (pop),
    .data_i      (sr_q[0]),
    .crc_o       (calc_crc)
  );

  // FCS words in arrival order: the line minus its oldest entry, then the current word.
  always_comb begin
    rx_fcs = '0;
    for (int i = 0; i < N - 1; i++) fcs_w[i] = sr_q[i+1];
    fcs_w[N-1] = data_i;
    for (int i = 0; i < N; i++) begin
      if (FCS_LSB_FIRST) rx_fcs[i*DATA_WIDTH +: DATA_WIDTH]       = fcs_w[i];
      else               rx_fcs[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = fcs_w[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the delay line is only N words, so it is cleared on reset like any other state.
      for (int i = 0; i < N; i++) sr_q[i] <= '0;
      state_q     <= ST_FILL;
      fcnt_q      <= '0;
      post_last_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      runt_q      <= 1'b0;
      rx_q        <= '0;
      calc_q      <= '0;
    end else begin
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      post_last_q <= 1'b0;
      if (valid_i) begin
        for (int i = 0; i < N - 1; i++) sr_q[i] <= sr_q[i+1];
        sr_q[N-1]   <= data_i;
        post_last_q <= last_i;
        if (state_q == ST_STREAM) begin
          valid_q <= 1'b1;
          data_q  <= sr_q[0];
          last_q  <= last_i;
        end
        if (last_i) begin
          done_q  <= 1'b1;
          runt_q  <= (state_q == ST_FILL);
          ok_q    <= (state_q == ST_STREAM) && (calc_crc == rx_fcs);
          rx_q    <= rx_fcs;
          calc_q  <= calc_crc;
          state_q <= ST_FILL;
          fcnt_q  <= '0;
        end else if (state_q == ST_FILL) begin
          fcnt_q <= fcnt_q + 1'b1;
          if (fcnt_q == FILL_MAX) state_q <= ST_STREAM;
        end
      end
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign done_o     = done_q;
  assign crc_ok_o   = ok_q;
  assign runt_o     = runt_q;
  assign rx_crc_o   = rx_q;
  assign calc_crc_o = calc_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: CRC-16/MAXIM and CRC-32 instances, good/bad/runt
// frames, back-to-back traffic with and without gaps, and mid-frame reset.
module tb_crc_check;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v16 = 1'b0, l16 = 1'b0, v32 = 1'b0, l32 = 1'b0;
  logic [7:0]  d16 = '0, d32 = '0;
  logic        vo16, lo16, done16, ok16, runt16;
  logic [7:0]  do16;
  logic [15:0] rx16, calc16;
  logic        vo32, lo32, done32, ok32, runt32;
  logic [7:0]  do32;
  logic [31:0] rx32, calc32;

  crc_check dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .data_i(d16), .last_i(l16),
    .valid_o(vo16), .data_o(do16), .last_o(lo16), .done_o(done16),
    .crc_ok_o(ok16), .runt_o(runt16), .rx_crc_o(rx16), .calc_crc_o(calc16)
  );

  crc_check #(
    .CRC_SIZE(32), .DATA_WIDTH(8), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .REF_IN(1'b1), .REF_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .FCS_LSB_FIRST(1'b1)
  ) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .data_i(d32), .last_i(l32),
    .valid_o(vo32), .data_o(do32), .last_o(lo32), .done_o(done32),
    .crc_ok_o(ok32), .runt_o(runt32), .rx_crc_o(rx32), .calc_crc_o(calc32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Output monitor, sampled on the falling edge.
  byte_q_t pay_q;
  logic    lastf_q[$];
  int      done_cnt = 0, ok_cnt = 0, runt_cnt = 0, done_nolast = 0, done32_cnt = 0;

  always @(negedge clk) begin
    if (vo16) begin
      pay_q.push_back(do16);
      lastf_q.push_back(lo16);
    end
    if (done16) begin
      done_cnt++;
      if (ok16) ok_cnt++;
      if (runt16) runt_cnt++;
      if (!runt16 && !lo16) done_nolast++;
    end
    if (done32) done32_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel32, input byte_q_t w, input int gap_max,
                      input bit hold, input bit no_last);
    int g;
    for (int i = 0; i < w.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        v16 = 1'b0; l16 = 1'b0; v32 = 1'b0; l32 = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      if (sel32) begin
        v32 = 1'b1; d32 = w[i]; l32 = !no_last && (i == w.size() - 1);
      end else begin
        v16 = 1'b1; d16 = w[i]; l16 = !no_last && (i == w.size() - 1);
      end
      @(posedge clk); #1;
    end
    if (!hold) begin
      v16 = 1'b0; l16 = 1'b0; v32 = 1'b0; l32 = 1'b0;
    end
  endtask

  task automatic wait_done(input bit sel32, input int target, output int lat);
    lat = 0;
    while (((sel32 ? done32_cnt : done_cnt) < target) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check(sel32 ? "done32_count" : "done16_count", sel32 ? done32_cnt : done_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t pa, fa, fa_bad, pa_bad, pb, fb, f32, exp_ab, run1, rnt1, rnt2;
    int      base, d0, ok0, r0, lat;

    pa  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fa  = pa; fa.push_back(8'hC2); fa.push_back(8'h44);
    pa_bad = pa; pa_bad[4] = 8'h34;
    fa_bad = pa_bad; fa_bad.push_back(8'hC2); fa_bad.push_back(8'h44);
    pb  = '{8'h00, 8'h00, 8'h01};
    fb  = pb; fb.push_back(8'h3E); fb.push_back(8'h3F);
    f32 = pa; f32.push_back(8'h26); f32.push_back(8'h39); f32.push_back(8'hF4); f32.push_back(8'hCB);
    exp_ab = pa; foreach (pb[i]) exp_ab.push_back(pb[i]);
    rnt1 = '{8'h12, 8'h34};
    rnt2 = '{8'h56};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", vo16, 0);
    check("rst_data_o", do16, 0);
    check("rst_last_o", lo16, 0);
    check("rst_done_o", done16, 0);
    check("rst_crc_ok_o", ok16, 0);
    check("rst_runt_o", runt16, 0);
    check("rst_rx_crc_o", rx16, 0);
    check("rst_calc_crc_o", calc16, 0);
    check("rst_calc32", calc32, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // CRC-16/MAXIM good frame
    base = pay_q.size(); d0 = done_cnt;
    send(1'b0, fa, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 1, lat);
    check("good_done_latency", lat, 1);
    check("good_pay_count", pay_q.size() - base, 9);
    for (int i = 0; i < 9; i++) check($sformatf("good_pay[%0d]", i), pay_q[base+i], pa[i]);
    check("good_last_on_0x39", lastf_q[base+8], 1);
    check("good_no_early_last", lastf_q[base+7], 0);
    check("good_crc_ok", ok16, 1);
    check("good_runt", runt16, 0);
    check("good_rx_crc", rx16, 16'h44C2);
    check("good_calc_crc", calc16, 16'h44C2);

    // Corrupted payload
    base = pay_q.size(); d0 = done_cnt;
    send(1'b0, fa_bad, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 1, lat);
    check("bad_pay_count", pay_q.size() - base, 9);
    for (int i = 0; i < 9; i++) check($sformatf("bad_pay[%0d]", i), pay_q[base+i], pa_bad[i]);
    check("bad_crc_ok", ok16, 0);
    check("bad_runt", runt16, 0);
    check("bad_rx_crc", rx16, 16'h44C2);

    // CRC-32
    d0 = done32_cnt;
    send(1'b1, f32, 0, 1'b0, 1'b0);
    wait_done(1'b1, d0 + 1, lat);
    check("crc32_ok", ok32, 1);
    check("crc32_runt", runt32, 0);
    check("crc32_calc", calc32, 32'hCBF43926);
    check("crc32_rx", rx32, 32'hCBF43926);

    // Back-to-back, no bubble
    base = pay_q.size(); d0 = done_cnt; ok0 = ok_cnt;
    send(1'b0, fa, 0, 1'b1, 1'b0);
    send(1'b0, fb, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 2, lat);
    check("b2b_ok_count", ok_cnt - ok0, 2);
    check("b2b_pay_count", pay_q.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("b2b_pay[%0d]", i), pay_q[base+i], exp_ab[i]);
      run1.push_back(pay_q[base+i]);
    end

    // Same frames with random gaps
    base = pay_q.size(); d0 = done_cnt; ok0 = ok_cnt;
    send(1'b0, fa, 3, 1'b1, 1'b0);
    send(1'b0, fb, 3, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 2, lat);
    check("gap_ok_count", ok_cnt - ok0, 2);
    check("gap_pay_count", pay_q.size() - base, 12);
    for (int i = 0; i < 12; i++) check($sformatf("gap_pay[%0d]", i), pay_q[base+i], run1[i]);

    // Runt frames: 2 words and 1 word
    base = pay_q.size(); d0 = done_cnt; ok0 = ok_cnt; r0 = runt_cnt;
    send(1'b0, rnt1, 0, 1'b1, 1'b0);
    send(1'b0, rnt2, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 2, lat);
    check("runt_no_payload", pay_q.size() - base, 0);
    check("runt_count", runt_cnt - r0, 2);
    check("runt_ok_count", ok_cnt - ok0, 0);
    check("runt_flag", runt16, 1);
    check("runt_crc_ok", ok16, 0);
    d0 = done_cnt;
    send(1'b0, fa, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 1, lat);
    check("after_runt_ok", ok16, 1);
    check("after_runt_runt", runt16, 0);

    // Reset after 5 words of a frame
    base = pay_q.size(); d0 = done_cnt;
    send(1'b0, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35}, 0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("prerst_valid_o", vo16, 1);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_o", vo16, 0);
    check("midrst_data_o", do16, 0);
    check("midrst_done_o", done16, 0);
    check("midrst_crc_ok_o", ok16, 0);
    check("midrst_rx_crc_o", rx16, 0);
    check("midrst_calc_crc_o", calc16, 0);
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_pay_count", pay_q.size() - base, 3);
    d0 = done_cnt;
    send(1'b0, fa, 0, 1'b0, 1'b0);
    wait_done(1'b0, d0 + 1, lat);
    check("after_rst_ok", ok16, 1);
    check("after_rst_calc", calc16, 16'h44C2);

    check("done_with_last_o", done_nolast, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side counterpart of the CRC generator. It takes a word stream whose trailing CRC_SIZE/DATA_WIDTH words carry the FCS, strips the FCS, and forwards the payload. It recomputes the CRC over the payload and reports a pass/fail verdict per frame. It sits between a deserializer/framer and the payload consumer, with no backpressure.

## Interface
- POLY, 16'h8005: generator polynomial, same encoding as the CRC engine.
- CRC_SIZE, 16: CRC width in bits. Must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 8: stream word width.
- INIT, 16'h0000: CRC seed.
- REF_IN, 1: reflect input words.
- REF_OUT, 1: reflected register output.
- XOR_OUT, 16'hffff: final XOR.
- FCS_LSB_FIRST, 1: 1 means the first FCS word on the wire is the CRC's least-significant word.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- valid_i  in  1  input word strobe.
- data_i  in  DATA_WIDTH  input word.
- last_i  in  1  marks the final word of the frame (the final FCS word).
- valid_o  out  1  payload word strobe.
- data_o  out  DATA_WIDTH  payload word.
- last_o  out  1  marks the final payload word.
- done_o  out  1  one-cycle pulse; frame verdict is valid.
- crc_ok_o  out  1  verdict: CRC matched. Held until the next done_o.
- runt_o  out  1  verdict: frame too short. Held until the next done_o.
- rx_crc_o  out  CRC_SIZE  received FCS. Held until the next done_o.
- calc_crc_o  out  CRC_SIZE  computed CRC, after XOR_OUT. Held until the next done_o.

## Operation
- FCS_WORDS = CRC_SIZE/DATA_WIDTH.
- Delay line: sr[0..FCS_WORDS-1] plus fill counter fcnt (0..FCS_WORDS). Together they form a FILL/STREAM state machine.
  - FILL (fcnt < FCS_WORDS): each accepted word is pushed and fcnt increments. Nothing is emitted.
  - STREAM (fcnt == FCS_WORDS): each accepted word is pushed and the oldest word pops.
  - The popped word goes to the payload output and to the CRC engine (valid asserted for that cycle).
- valid_i low: no state change. Gaps of any length are allowed mid-frame.
- Beat with last_i in STREAM:
  - The popped word is output with last_o=1.
  - The FCS_WORDS words now in the line, including the current word, form rx FCS w0..wN-1 in arrival order.
  - FCS_LSB_FIRST=1: rx = {wN-1,…,w0}. FCS_LSB_FIRST=0: rx = {w0,…,wN-1}.
  - fcnt returns to 0, so the next frame starts in FILL.
- Beat with last_i in FILL (frame of ≤ FCS_WORDS words): runt.
  - No payload beats are emitted.
  - Verdict is runt_o=1, crc_ok_o=0.
  - fcnt returns to 0.
- Verdict: crc_ok_o = (engine CRC ^ XOR_OUT) == rx. Both values are also latched to calc_crc_o and rx_crc_o.
- Engine soft reset is asserted the cycle after any last_i beat. No engine update can coincide with it, because fcnt=0 means no pop.
- Reset values:
  - Outputs: all outputs 0.
  - Internal state: fcnt=0; delay line cleared; engine=INIT.
- rst_i mid-frame: the partial frame is discarded, no done_o is generated, and the block restarts in FILL.

## Timing
- Payload latency: data word k appears on data_o/valid_o one cycle after the input beat carrying word k+FCS_WORDS.
- All outputs are registered.
- done_o fires exactly one cycle after the last_i beat. It coincides with last_o for a non-runt frame.
- Back-to-back frames: valid_i may carry the next frame's first word on the cycle right after last_i. Full throughput, no bubble.
- A new done_o overwrites the held verdict fields in the same cycle.

## Structure
- Package crc_check_pkg holds:
  - fsm state enum (FILL, STREAM);
  - function fcs_words(crc_size, data_width).
- Elaboration check: error if CRC_SIZE % DATA_WIDTH != 0.
- One sub-module, crc_calc, instanced with the same POLY/CRC_SIZE/DATA_WIDTH/INIT/REF_IN/REF_OUT/XOR_OUT.
  - valid_i connects to the pop strobe; soft_reset_i connects to the post-last strobe.
  - Its crc_o is used as the computed CRC.

## Test plan
- CRC-16/MAXIM defaults, frame "123456789" (0x31..0x39) followed by 0xC2, 0x44:
  - 9 payload words out, last_o on 0x39;
  - done_o, crc_ok_o=1, rx_crc_o=calc_crc_o=16'h44C2.
- Same frame with bit 0 of 0x35 flipped: payload forwarded unchanged; crc_ok_o=0 and rx_crc_o=16'h44C2.
- CRC-32 (POLY 04C11DB7, INIT/XOR FFFFFFFF, reflected), "123456789" + 0x26 0x39 0xF4 0xCB: crc_ok_o=1, calc_crc_o=32'hCBF43926.
- Two good frames back-to-back with no idle cycle, then the same frames with random valid_i gaps: two done_o pulses, both ok, payload identical in both runs.
- 2-word frame with CRC_SIZE=16 and a 1-word frame: no valid_o, done_o with runt_o=1, crc_ok_o=0; the next good frame passes.
- rst_i asserted after 5 words of a frame:
  - outputs are 0 the next cycle and no done_o follows;
  - a subsequent good frame passes.
